// File: rtl/console_session_mux.sv
// Multi-session console switch: per-channel RX FIFOs, one selected session forwarded to the
// VT100 path, keyboard routed to the selected transmitter. CONSOLE_MUX_CLEAR_EN adds a screen clear per switch.
module console_session_mux #(
    parameter int CHANNELS   = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                           clk100M,
    input  logic                           rst,
    input  logic [CHANNELS*DATA_WIDTH-1:0] rx_data,
    input  logic [CHANNELS-1:0]            rx_valid,
    output logic [CHANNELS-1:0]            rx_overflow,
    input  logic                           sel_next,
    input  logic                           sel_prev,
    output logic [$clog2(CHANNELS)-1:0]    active,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    input  logic [DATA_WIDTH-1:0]          kb_data,
    input  logic                           kb_valid,
    output logic                           kb_ready,
    output logic [DATA_WIDTH-1:0]          tx_data,
    output logic [CHANNELS-1:0]            tx_valid,
    input  logic [CHANNELS-1:0]            tx_ready
);
    localparam int SEL_W = $clog2(CHANNELS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Handshake: a byte transfers at a rising edge where valid & ready; valid never depends on
    // ready, and out_data/out_valid hold steady while out_valid & !out_ready.

`ifdef CONSOLE_MUX_CLEAR_EN
    typedef enum logic {FWD, CLR} state_t;
    logic [2:0] clr_idx;

    function automatic logic [DATA_WIDTH-1:0] clr_byte(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd4: return DATA_WIDTH'(8'h1B);
            3'd1, 3'd5: return DATA_WIDTH'(8'h5B);
            3'd2:       return DATA_WIDTH'(8'h32);
            3'd3:       return DATA_WIDTH'(8'h4A);
            default:    return DATA_WIDTH'(8'h48);
        endcase
    endfunction
`else
    typedef enum logic {FWD} state_t;
`endif

    function automatic logic [SEL_W-1:0] step_sel(input logic [SEL_W-1:0] cur, input logic up);
        if (up) return (cur == SEL_W'(CHANNELS - 1)) ? '0 : cur + SEL_W'(1);
        return (cur == '0) ? SEL_W'(CHANNELS - 1) : cur - SEL_W'(1);
    endfunction

    logic [DATA_WIDTH-1:0] mem    [CHANNELS][FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr [CHANNELS];
    logic [PTR_W-1:0]      rd_ptr [CHANNELS];
    logic [CNT_W-1:0]      count  [CHANNELS];
    logic [CHANNELS-1:0]   wr_en;
    logic [CHANNELS-1:0]   pop_vec;

    state_t                state;
    logic                  pend_valid;
    logic [SEL_W-1:0]      pend_target;
    logic [SEL_W-1:0]      base;
    logic [SEL_W-1:0]      target;
    logic                  stall;
    logic                  press;
    logic                  apply;
    logic                  pop;
    logic                  head_empty;
    logic [DATA_WIDTH-1:0] head_data;

    always_comb begin
        stall      = out_valid && !out_ready;
        press      = sel_next ^ sel_prev;
        base       = pend_valid ? pend_target : active;
        target     = step_sel(base, sel_next);
        apply      = pend_valid && (state == FWD) && !stall;
        head_empty = (count[active] == '0);
        head_data  = mem[active][rd_ptr[active]];
        // The switch edge itself moves no FIFO byte, so nothing from the old session follows it.
        pop        = (state == FWD) && !apply && !stall && !head_empty;
        for (int i = 0; i < CHANNELS; i++) begin
            pop_vec[i] = pop && (active == SEL_W'(i));
            wr_en[i]   = rx_valid[i] && ((count[i] != CNT_W'(FIFO_DEPTH)) || pop_vec[i]);
        end
    end

    always_ff @(posedge clk100M) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_en[i]) mem[i][wr_ptr[i]] <= rx_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk100M) begin
        if (rst) begin
            rx_overflow <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_en[i])   wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop_vec[i]) rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                case ({wr_en[i], pop_vec[i]})
                    2'b10:   count[i] <= count[i] + CNT_W'(1);
                    2'b01:   count[i] <= count[i] - CNT_W'(1);
                    default: ;
                endcase
                if (rx_valid[i] && !wr_en[i]) rx_overflow[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk100M) begin
        if (rst) begin
            state       <= FWD;
            active      <= '0;
            pend_valid  <= 1'b0;
            pend_target <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
`ifdef CONSOLE_MUX_CLEAR_EN
            clr_idx     <= '0;
`endif
        end else begin
            if (press) begin
                pend_valid  <= 1'b1;
                pend_target <= target;
            end else if (apply) begin
                pend_valid  <= 1'b0;
            end
            if (!stall) begin
                out_valid <= 1'b0;
                case (state)
                    FWD: begin
                        if (apply) begin
                            active <= pend_target;
`ifdef CONSOLE_MUX_CLEAR_EN
                            state   <= CLR;
                            clr_idx <= '0;
`endif
                        end else if (!head_empty) begin
                            out_valid <= 1'b1;
                            out_data  <= head_data;
                        end
                    end
`ifdef CONSOLE_MUX_CLEAR_EN
                    CLR: begin
                        out_valid <= 1'b1;
                        out_data  <= clr_byte(clr_idx);
                        clr_idx   <= clr_idx + 3'd1;
                        if (clr_idx == 3'd6) state <= FWD;
                    end
`endif
                    default: state <= FWD;
                endcase
            end
        end
    end

    always_comb begin
        tx_data          = kb_data;
        tx_valid         = '0;
        tx_valid[active] = kb_valid;
        kb_ready         = tx_ready[active];
    end

endmodule

// File: tb/tb_console_session_mux.sv
// Bench for console_session_mux: scenario tasks with inline checks against a queue-based model.
// Honours CONSOLE_MUX_CLEAR_EN the same way the design does.
module tb_console_session_mux;
    localparam int CH    = 4;
    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int SW    = 2;
`ifdef CONSOLE_MUX_CLEAR_EN
    localparam int CLR_N = 7;
`else
    localparam int CLR_N = 0;
`endif

    logic             clk100M = 1'b0;
    logic             rst;
    logic [CH*DW-1:0] rx_data;
    logic [CH-1:0]    rx_valid;
    logic [CH-1:0]    rx_overflow;
    logic             sel_next;
    logic             sel_prev;
    logic [SW-1:0]    active;
    logic [DW-1:0]    out_data;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    kb_data;
    logic             kb_valid;
    logic             kb_ready;
    logic [DW-1:0]    tx_data;
    logic [CH-1:0]    tx_valid;
    logic [CH-1:0]    tx_ready;

    console_session_mux #(.CHANNELS(CH), .FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk100M(clk100M), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_overflow(rx_overflow), .sel_next(sel_next), .sel_prev(sel_prev), .active(active),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .kb_data(kb_data),
        .kb_valid(kb_valid), .kb_ready(kb_ready), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    always #5 clk100M = ~clk100M;

    int            n_cmp = 0;
    int            n_err = 0;
    int            m_active;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    logic          timed_out;
    logic [DW-1:0] clr_seq [7] = '{8'h1B, 8'h5B, 8'h32, 8'h4A, 8'h1B, 8'h5B, 8'h48};

    function automatic int model_sel(input int cur, input bit up);
        return up ? (cur + 1) % CH : (cur + CH - 1) % CH;
    endfunction

    task automatic step();
        @(posedge clk100M);
        #1;
    endtask

    task automatic press(input logic nx, input logic pv);
        sel_next = nx;
        sel_prev = pv;
        step();
        sel_next = 1'b0;
        sel_prev = 1'b0;
    endtask

    task automatic write_byte(input int ch, input logic [DW-1:0] b);
        rx_valid                = '0;
        rx_valid[ch]            = 1'b1;
        rx_data[ch*DW +: DW]    = b;
        step();
        rx_valid                = '0;
    endtask

    // Accepts bytes with out_ready high until n are gathered or the budget runs out.
    task automatic collect(input int n, input int budget);
        int cyc;
        cyc = 0;
        got_q.delete();
        out_ready = 1'b1;
        while (got_q.size() < n && cyc < budget) begin
            if (out_valid) got_q.push_back(out_data);
            step();
            cyc++;
        end
        timed_out = (got_q.size() < n);
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_valid = '0; rx_data = '0; sel_next = 0; sel_prev = 0;
        out_ready = 1'b0; kb_data = '0; kb_valid = 1'b0; tx_ready = 4'b0001;
        repeat (2) step();
        rst = 1'b0;
        m_active = 0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h, expected 00", out_data); end
        n_cmp++; if (active !== 2'd0) begin n_err++; $display("FAIL reset_active: got %0d, expected 0", active); end
        n_cmp++; if (rx_overflow !== 4'b0000) begin n_err++; $display("FAIL reset_overflow: got %b, expected 0000", rx_overflow); end
        n_cmp++; if (tx_valid !== 4'b0000 || kb_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_kb: got tx_valid=%b kb_ready=%b, expected 0000/1", tx_valid, kb_ready); end
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        write_byte(0, 8'h41);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL latency_edge_n: got valid=%b, expected 0", out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h41) begin
            n_err++; $display("FAIL latency_edge_n1: got valid=%b data=%h, expected 1/41", out_valid, out_data); end
        n_cmp++; if (active !== 2'd0) begin n_err++; $display("FAIL latency_active: got %0d, expected 0", active); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL latency_drained: got valid=%b, expected 0", out_valid); end
    endtask

    task automatic test_random_stream();
        logic          stall_prev;
        logic [DW-1:0] held;
        logic [DW-1:0] b;
        logic [DW-1:0] e;
        int            cyc;
        stall_prev = 1'b0;
        held       = '0;
        exp_q.delete();
        for (int c = 0; c < 300; c++) begin
            if (stall_prev) begin
                n_cmp++; if (out_valid !== 1'b1 || out_data !== held) begin
                    n_err++; $display("FAIL stream_stable: got valid=%b data=%h, expected 1/%h", out_valid, out_data, held); end
            end
            out_ready = ($urandom_range(0, 9) < 7);
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL stream_extra: got %h, expected no byte", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin n_err++; $display("FAIL stream_data: got %h, expected %h", out_data, e); end
                end
            end
            rx_valid = '0;
            if (exp_q.size() < DEPTH && $urandom_range(0, 1) == 1) begin
                b = DW'($urandom);
                rx_data[0 +: DW] = b;
                rx_valid[0]      = 1'b1;
                exp_q.push_back(b);
            end
            stall_prev = out_valid && !out_ready;
            held       = out_data;
            step();
        end
        rx_valid  = '0;
        out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 60) begin
            if (out_valid) begin
                e = exp_q.pop_front();
                n_cmp++; if (out_data !== e) begin n_err++; $display("FAIL stream_drain: got %h, expected %h", out_data, e); end
            end
            step();
            cyc++;
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL stream_timeout: got %0d left, expected 0", exp_q.size()); end
        n_cmp++; if (rx_overflow !== 4'b0000) begin n_err++; $display("FAIL stream_overflow: got %b, expected 0000", rx_overflow); end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] b;
        exp_q.delete();
        for (int k = 0; k <= DEPTH; k++) begin
            b = DW'($urandom);
            if (k < DEPTH) exp_q.push_back(b);
            write_byte(2, b);
            if (k == DEPTH - 1) begin
                n_cmp++; if (rx_overflow[2] !== 1'b0) begin n_err++; $display("FAIL ovf_at_full: got %b, expected 0", rx_overflow[2]); end
            end
        end
        n_cmp++; if (rx_overflow !== 4'b0100) begin n_err++; $display("FAIL ovf_set: got %b, expected 0100", rx_overflow); end
        press(1'b1, 1'b0);
        m_active = model_sel(m_active, 1'b1);
        collect(CLR_N, 40);
        repeat (3) step();
        n_cmp++; if (active !== SW'(m_active)) begin n_err++; $display("FAIL ovf_hop: got %0d, expected %0d", active, m_active); end
        press(1'b1, 1'b0);
        m_active = model_sel(m_active, 1'b1);
        collect(CLR_N + DEPTH, 100);
        n_cmp++; if (timed_out) begin n_err++; $display("FAIL ovf_count: got %0d bytes, expected %0d", got_q.size(), CLR_N + DEPTH); end
        for (int i = 0; i < got_q.size(); i++) begin
            if (i < CLR_N) begin
                n_cmp++; if (got_q[i] !== clr_seq[i]) begin n_err++; $display("FAIL ovf_clr[%0d]: got %h, expected %h", i, got_q[i], clr_seq[i]); end
            end else begin
                n_cmp++; if (got_q[i] !== exp_q[i-CLR_N]) begin n_err++; $display("FAIL ovf_data[%0d]: got %h, expected %h", i, got_q[i], exp_q[i-CLR_N]); end
            end
        end
        n_cmp++; if (active !== 2'd2 || rx_overflow !== 4'b0100) begin
            n_err++; $display("FAIL ovf_after: got active=%0d ovf=%b, expected 2/0100", active, rx_overflow); end
        timed_out = 1'b0;
        repeat (5) begin if (out_valid) timed_out = 1'b1; step(); end
        n_cmp++; if (timed_out) begin n_err++; $display("FAIL ovf_extra: got extra byte, expected exactly %0d", DEPTH); end
    endtask

    task automatic test_select();
        bit up [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            press(up[i], !up[i]);
            m_active = model_sel(m_active, up[i]);
            collect(CLR_N, 40);
            repeat (3) step();
            n_cmp++; if (active !== SW'(m_active)) begin n_err++; $display("FAIL select_%0d: got %0d, expected %0d", i, active, m_active); end
        end
        press(1'b1, 1'b1);
        repeat (3) step();
        n_cmp++; if (active !== SW'(m_active) || out_valid !== 1'b0) begin
            n_err++; $display("FAIL select_both: got active=%0d valid=%b, expected %0d/0", active, out_valid, m_active); end
    endtask

    task automatic test_stall_switch();
        out_ready = 1'b0;
        write_byte(m_active, 8'h55);
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h55) begin
            n_err++; $display("FAIL stall_load: got valid=%b data=%h, expected 1/55", out_valid, out_data); end
        press(1'b1, 1'b0);
        repeat (3) begin
            n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h55 || active !== SW'(m_active)) begin
                n_err++; $display("FAIL stall_hold: got valid=%b data=%h active=%0d, expected 1/55/%0d", out_valid, out_data, active, m_active); end
            step();
        end
        out_ready = 1'b1;
        step();
        m_active = model_sel(m_active, 1'b1);
        n_cmp++; if (active !== SW'(m_active) || out_valid !== 1'b0) begin
            n_err++; $display("FAIL stall_apply: got active=%0d valid=%b, expected %0d/0", active, out_valid, m_active); end
        collect(CLR_N, 40);
        for (int i = 0; i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== clr_seq[i]) begin n_err++; $display("FAIL stall_clr[%0d]: got %h, expected %h", i, got_q[i], clr_seq[i]); end
        end
        // Two presses while stalled: the second builds on the first pending target.
        out_ready = 1'b0;
        write_byte(m_active, 8'h56);
        step();
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        n_cmp++; if (active !== SW'(m_active) || out_data !== 8'h56) begin
            n_err++; $display("FAIL stall2_hold: got active=%0d data=%h, expected %0d/56", active, out_data, m_active); end
        out_ready = 1'b1;
        step();
        m_active = model_sel(model_sel(m_active, 1'b1), 1'b1);
        n_cmp++; if (active !== SW'(m_active)) begin n_err++; $display("FAIL stall2_jump: got %0d, expected %0d", active, m_active); end
        collect(CLR_N, 40);
        timed_out = 1'b0;
        repeat (8) begin if (out_valid) timed_out = 1'b1; step(); end
        n_cmp++; if (timed_out) begin n_err++; $display("FAIL stall2_extra: got extra byte, expected none"); end
    endtask

    task automatic test_clear();
        int nxt;
        nxt = model_sel(m_active, 1'b1);
        out_ready = 1'b1;
        write_byte(nxt, 8'h61);
        press(1'b1, 1'b0);
        m_active = nxt;
        collect(CLR_N + 1, 60);
        n_cmp++; if (timed_out) begin n_err++; $display("FAIL clear_count: got %0d bytes, expected %0d", got_q.size(), CLR_N + 1); end
        for (int i = 0; i < got_q.size(); i++) begin
            n_cmp++;
            if (i < CLR_N) begin
                if (got_q[i] !== clr_seq[i]) begin n_err++; $display("FAIL clear_seq[%0d]: got %h, expected %h", i, got_q[i], clr_seq[i]); end
            end else if (got_q[i] !== 8'h61) begin
                n_err++; $display("FAIL clear_data: got %h, expected 61", got_q[i]);
            end
        end
        timed_out = 1'b0;
        repeat (5) begin if (out_valid) timed_out = 1'b1; step(); end
        n_cmp++; if (timed_out || active !== SW'(m_active)) begin
            n_err++; $display("FAIL clear_after: got extra=%b active=%0d, expected 0/%0d", timed_out, active, m_active); end
    endtask

    task automatic test_keyboard();
        int            nxt;
        logic [CH-1:0] exp_tx;
        nxt = model_sel(m_active, 1'b1);
        kb_data  = 8'h0D;
        kb_valid = 1'b1;
        tx_ready = '0;
        tx_ready[nxt] = 1'b1;
        step();
        n_cmp++; if (tx_valid !== CH'(1) << m_active || tx_data !== 8'h0D || kb_ready !== 1'b0) begin
            n_err++; $display("FAIL kb_before: got tx_valid=%b data=%h ready=%b, expected %b/0d/0", tx_valid, tx_data, kb_ready, CH'(1) << m_active); end
        press(1'b1, 1'b0);
        m_active = nxt;
        collect(CLR_N, 40);
        repeat (2) step();
        n_cmp++; if (tx_valid !== CH'(1) << m_active || kb_ready !== 1'b1) begin
            n_err++; $display("FAIL kb_after: got tx_valid=%b ready=%b, expected %b/1", tx_valid, kb_ready, CH'(1) << m_active); end
        for (int i = 0; i < 24; i++) begin
            kb_valid = 1'($urandom_range(0, 1));
            kb_data  = DW'($urandom);
            tx_ready = CH'($urandom);
            #1;
            exp_tx = kb_valid ? (CH'(1) << m_active) : '0;
            n_cmp++; if (tx_valid !== exp_tx || tx_data !== kb_data || kb_ready !== tx_ready[m_active]) begin
                n_err++; $display("FAIL kb_rand: got %b/%h/%b, expected %b/%h/%b", tx_valid, tx_data, kb_ready, exp_tx, kb_data, tx_ready[m_active]); end
            step();
        end
        kb_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        write_byte(m_active, 8'h71);
        write_byte(m_active, 8'h72);
        write_byte(m_active, 8'h73);
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h71) begin
            n_err++; $display("FAIL rstmid_held: got valid=%b data=%h, expected 1/71", out_valid, out_data); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'h00 || active !== 2'd0 || rx_overflow !== 4'b0000) begin
            n_err++; $display("FAIL rstmid_state: got %b/%h/%0d/%b, expected 0/00/0/0000", out_valid, out_data, active, rx_overflow); end
        press(1'b1, 1'b0);
        m_active = 1;
        collect(CLR_N, 40);
        timed_out = 1'b0;
        repeat (6) begin if (out_valid) timed_out = 1'b1; step(); end
        n_cmp++; if (timed_out || active !== 2'd1) begin
            n_err++; $display("FAIL rstmid_flushed: got stale=%b active=%0d, expected 0/1", timed_out, active); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_random_stream();
        test_overflow();
        test_select();
        test_stall_switch();
        test_clear();
        test_keyboard();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected earlier finish");
        $fatal(1, "watchdog expired");
    end

endmodule
